aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Sequential AES key-schedule engine producing every round key for AES-128, AES-192 and AES-256, selected per run by a mode input. It replaces the single-step combinational round-key generator. Words are generated one 32-bit word per cycle into an internal round-key store. The cipher datapath reads any round key by index once the schedule is valid.

## Interface
- MAX_KEY_BITS, default 256: largest key size supported (128, 192 or 256); sizes the word store to 4*(MAX_KEY_BITS/32+7) words.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to expand key_in; sampled only in IDLE.
- key_len  in  2  00=128, 01=192, 10=256, 11=illegal; sampled with start.
- key_in  in  256  cipher key, left-justified; w[0] = key_in[255:224]; unused low bits ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last word is written.
- keys_valid  out  1  level; store holds a complete schedule for the latched key_len.
- err  out  1  one-cycle pulse when start is rejected for an illegal or unsupported key_len.
- rd_round  in  4  round-key index 0..Nr.
- rd_key  out  128  {w[4r], w[4r+1], w[4r+2], w[4r+3]}, combinational from the store.

## Operation
- Nk = 4/6/8, Nr = Nk+6, total words Nw = 4*(Nr+1) = 44/52/60.
- FSM states:
  - IDLE: on start with a legal key_len (Nk*32 <= MAX_KEY_BITS), write w[0..Nk-1] from key_in, latch Nk, set i=Nk, clear keys_valid, go to EXPAND. Illegal or unsupported key_len: pulse err, stay in IDLE, leave the store and keys_valid unchanged.
  - EXPAND: each cycle compute temp from w[i-1], write w[i] = w[i-Nk] ^ temp, then i++. When i = Nw-1 is written, go to DONE.
  - DONE: a single cycle. done=1, keys_valid set, then IDLE.
- temp rules:
  - i mod Nk = 0: SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
  - Nk = 8 and i mod 8 = 4: SubWord(w[i-1]).
  - Otherwise: w[i-1].
- Rotation: RotWord rotates left by one byte. Rcon = 01,02,04,08,10,20,40,80,1B,36.
- start while busy or in DONE is ignored; no queueing.
- rd_round > Nr of the latched mode: rd_key = 0. Reads during EXPAND return current store contents; consumers gate on keys_valid.
- Store words above Nw-1 keep stale data and are never read back.

## Timing
- Reset values: busy=0, done=0, keys_valid=0, err=0, FSM=IDLE, i=0, store cleared to 0, rd_key=0.
- start sampled at edge E0. Words w[Nk]..w[Nw-1] are written at edges E1..E(Nw-Nk): 40/46/52 cycles.
- busy is high from after E0 through the cycle containing the last write. done and keys_valid rise after edge E(Nw-Nk+1).
- Start-to-done latency: 41/47/53 cycles. Back-to-back: a new start is accepted the cycle after done.
- err is asserted for the single cycle following the rejected start edge.
- rst asserted mid-expansion: all outputs and the store go to reset values immediately. No partial schedule is flagged valid.

## Structure
- Package aes_key_pkg: key_len_t enum, RCON constant array [1:10], functions nk_of(key_len_t) and nr_of(key_len_t).
- Sub-module aes_sbox: combinational 8-bit S-box lookup, instantiated four times for SubWord.
- The top level holds the FSM, word counter i, phase counter (i mod Nk), word store and read mux.

## Test plan
- AES-128, key 2B7E151628AED2A6ABF7158809CF4F3C -> w[4]=A0FAFE17; done 41 cycles after start; rd_round=10 gives D014F9A8C9EE2589E13F0CC8B6630CA6.
- AES-192, key 8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B -> w[6]=FE0C91F7; done after 47 cycles; rd_round=12 gives E98BA06F448C773C8ECC720401002202.
- AES-256, key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4 -> w[8]=9BA35411; done after 53 cycles; rd_round=14 gives FE4890D1E6188D0B046DF344706C631E.
- key_len=11, or key_len=10 with MAX_KEY_BITS=128 -> one-cycle err pulse, busy stays 0, and the prior schedule and keys_valid are retained.
- Second start pulsed mid-expansion -> ignored, latency unchanged. rd_round=11 in 128 mode -> rd_key=0.
- rst pulsed at cycle 20 of an AES-256 run -> all outputs 0 and rd_key=0. A fresh AES-128 start then completes correctly.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared types and constants for the AES key-schedule engine.
package aes_key_pkg;

  typedef enum logic [1:0] {
    KeyLen128 = 2'b00,
    KeyLen192 = 2'b01,
    KeyLen256 = 2'b10,
    KeyLenBad = 2'b11
  } key_len_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StDone
  } state_t;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [3:0] nk_of(input key_len_t keyLen);
    case (keyLen)
      KeyLen128: return 4'd4;
      KeyLen192: return 4'd6;
      KeyLen256: return 4'd8;
      default:   return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_len_t keyLen);
    return (keyLen == KeyLenBad) ? 4'd0 : nk_of(keyLen) + 4'd6;
  endfunction

  // Out-of-table indices yield 0 so the counter may run one past the last round.
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    if (idx >= 4'd1 && idx <= 4'd10) return RCON[idx];
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox (
  input  logic [7:0] byteVal,
  output logic [7:0] subVal
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b,
    8'hfe, 8'hd7, 8'hab, 8'h76, 8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0, 8'hb7, 8'hfd, 8'h93, 8'h26,
    8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2,
    8'heb, 8'h27, 8'hb2, 8'h75, 8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84, 8'h53, 8'hd1, 8'h00, 8'hed,
    8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f,
    8'h50, 8'h3c, 8'h9f, 8'ha8, 8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2, 8'hcd, 8'h0c, 8'h13, 8'hec,
    8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14,
    8'hde, 8'h5e, 8'h0b, 8'hdb, 8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79, 8'he7, 8'hc8, 8'h37, 8'h6d,
    8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f,
    8'h4b, 8'hbd, 8'h8b, 8'h8a, 8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e, 8'he1, 8'hf8, 8'h98, 8'h11,
    8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f,
    8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign subVal = SBOX[byteVal];

endmodule

// File: rtl/aes_key_expander.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per cycle into a
// round-key store, with a combinational round-key read port.
module aes_key_expander
  import aes_key_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         err,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key
);

  localparam int unsigned Depth = 4 * (MAX_KEY_BITS / 32 + 7);
  localparam int unsigned IdxW  = $clog2(Depth);

  state_t          stateQ, stateD;
  logic [IdxW-1:0] wordIdxQ, wordIdxD;
  logic [2:0]      phaseQ, phaseD;
  logic [3:0]      rconIdxQ, rconIdxD;
  logic [3:0]      nkQ, nkD;
  logic            keysValidQ, keysValidD;
  logic            doneQ, doneD;
  logic            errQ, errD;
  logic            loadKey, writeWord;

  logic [31:0]     store [Depth];

  key_len_t        keyLenSel;
  logic [3:0]      nkNew;
  logic            startLegal;
  logic [IdxW-1:0] prevIdx, backIdx, lastIdx, rdBase;
  logic [31:0]     prevWord, backWord, sboxIn, subWord, temp;
  logic [3:0]      nrQ;

  assign keyLenSel  = key_len_t'(key_len);
  assign nkNew      = nk_of(keyLenSel);
  assign startLegal = (keyLenSel != KeyLenBad) && (32'(nkNew) * 32'd32 <= MAX_KEY_BITS);

  assign prevIdx  = wordIdxQ - IdxW'(1);
  assign backIdx  = wordIdxQ - IdxW'(nkQ);
  assign lastIdx  = IdxW'({nkQ + 4'd7, 2'b00} - 6'd1);
  assign prevWord = store[prevIdx];
  assign backWord = store[backIdx];

  // Phase 0 substitutes the rotated word; the AES-256 mid-phase substitutes it unrotated.
  assign sboxIn = (phaseQ == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;

  for (genvar g = 0; g < 4; g++) begin : gen_sub_word
    aes_sbox sboxInst (
      .byteVal(sboxIn[8*g +: 8]),
      .subVal (subWord[8*g +: 8])
    );
  end

  always_comb begin
    temp = prevWord;
    if (phaseQ == 3'd0) begin
      temp = subWord ^ {rcon_of(rconIdxQ), 24'h0};
    end else if (nkQ == 4'd8 && phaseQ == 3'd4) begin
      temp = subWord;
    end
  end

  always_comb begin
    stateD     = stateQ;
    wordIdxD   = wordIdxQ;
    phaseD     = phaseQ;
    rconIdxD   = rconIdxQ;
    nkD        = nkQ;
    keysValidD = keysValidQ;
    doneD      = 1'b0;
    errD       = 1'b0;
    loadKey    = 1'b0;
    writeWord  = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (start) begin
          if (startLegal) begin
            loadKey    = 1'b1;
            nkD        = nkNew;
            wordIdxD   = IdxW'(nkNew);
            phaseD     = 3'd0;
            rconIdxD   = 4'd1;
            keysValidD = 1'b0;
            stateD     = StExpand;
          end else begin
            errD = 1'b1;
          end
        end
      end
      StExpand: begin
        writeWord = 1'b1;
        wordIdxD  = wordIdxQ + IdxW'(1);
        if ({1'b0, phaseQ} == nkQ - 4'd1) begin
          phaseD   = 3'd0;
          rconIdxD = rconIdxQ + 4'd1;
        end else begin
          phaseD = phaseQ + 3'd1;
        end
        if (wordIdxQ == lastIdx) stateD = StDone;
      end
      StDone: begin
        doneD      = 1'b1;
        keysValidD = 1'b1;
        stateD     = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= StIdle;
      wordIdxQ   <= '0;
      phaseQ     <= '0;
      rconIdxQ   <= '0;
      nkQ        <= 4'd4;
      keysValidQ <= 1'b0;
      doneQ      <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      stateQ     <= stateD;
      wordIdxQ   <= wordIdxD;
      phaseQ     <= phaseD;
      rconIdxQ   <= rconIdxD;
      nkQ        <= nkD;
      keysValidQ <= keysValidD;
      doneQ      <= doneD;
      errQ       <= errD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(Depth); k++) store[k] <= '0;
    end else begin
      if (loadKey) begin
        for (int k = 0; k < 8; k++) begin
          if (k < int'(nkNew)) store[k] <= key_in[255 - 32*k -: 32];
        end
      end
      if (writeWord) store[wordIdxQ] <= backWord ^ temp;
    end
  end

  assign nrQ    = nkQ + 4'd6;
  assign rdBase = IdxW'({rd_round, 2'b00});

  always_comb begin
    rd_key = '0;
    if (rd_round <= nrQ) begin
      rd_key = {store[rdBase], store[rdBase + IdxW'(1)], store[rdBase + IdxW'(2)],
                store[rdBase + IdxW'(3)]};
    end
  end

  assign busy       = (stateQ == StExpand);
  assign done       = doneQ;
  assign keys_valid = keysValidQ;
  assign err        = errQ;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
module tb_aes_key_expander;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   keyLen;
  logic [255:0] keyIn;
  logic [3:0]   rdRound, rdRound128;
  logic         busy, done, keysValid, err;
  logic [127:0] rdKey;
  logic         busy128, done128, keysValid128, err128;
  logic [127:0] rdKey128;

  int checks = 0;
  int errors = 0;
  int lat;

  localparam logic [255:0] K128 = {128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h0};
  localparam logic [255:0] K192 = {192'h8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B, 64'h0};
  localparam logic [255:0] K256 =
    256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
  localparam logic [127:0] R128_10 = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
  localparam logic [127:0] R192_12 = 128'hE98BA06F448C773C8ECC720401002202;
  localparam logic [127:0] R256_14 = 128'hFE4890D1E6188D0B046DF344706C631E;

  always #5 clk = ~clk;

  aes_key_expander #(.MAX_KEY_BITS(256)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(keyLen), .key_in(keyIn),
    .busy(busy), .done(done), .keys_valid(keysValid), .err(err),
    .rd_round(rdRound), .rd_key(rdKey)
  );

  aes_key_expander #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start), .key_len(keyLen), .key_in(keyIn),
    .busy(busy128), .done(done128), .keys_valid(keysValid128), .err(err128),
    .rd_round(rdRound128), .rd_key(rdKey128)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Pulses start for edge E0 and returns #1 after E0.
  task automatic kick(input logic [1:0] kl, input logic [255:0] key);
    @(negedge clk);
    start  = 1'b1;
    keyLen = kl;
    keyIn  = key;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("valid_cleared_on_start", keysValid, 1'b0);
  endtask

  // Counts edges after E0 until done; optionally pulses a stray start mid-run.
  task automatic waitDone(input int injectAt, output int cycles);
    cycles = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == injectAt) begin
        start  = 1'b1;
        keyLen = 2'b10;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        cycles = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    keyLen     = 2'b00;
    keyIn      = '0;
    rdRound    = 4'd0;
    rdRound128 = 4'd10;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_valid", keysValid, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_rdkey", rdKey, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // AES-128 with a stray start injected mid-expansion
    rdRound = 4'd10;
    kick(2'b00, K128);
    waitDone(10, lat);
    chk("lat128", 128'(lat), 128'd41);
    chk("rk128_r10", rdKey, R128_10);
    rdRound = 4'd0;
    #1 chk("rk128_r0", rdKey, K128[255:128]);
    rdRound = 4'd1;
    #1 chk("w4_128", rdKey[127:96], 32'hA0FAFE17);
    rdRound = 4'd11;
    #1 chk("rd_beyond_nr", rdKey, 128'h0);
    @(posedge clk);
    #1;
    chk("done_single_pulse", done, 1'b0);
    chk("valid_held", keysValid, 1'b1);

    // Illegal key_len
    @(negedge clk);
    start  = 1'b1;
    keyLen = 2'b11;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    chk("err_no_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("err_one_cycle", err, 1'b0);
    chk("err_valid_kept", keysValid, 1'b1);
    rdRound = 4'd10;
    #1 chk("err_store_kept", rdKey, R128_10);

    // AES-192, then AES-256 back-to-back
    rdRound = 4'd12;
    kick(2'b01, K192);
    waitDone(0, lat);
    chk("lat192", 128'(lat), 128'd47);
    chk("rk192_r12", rdKey, R192_12);
    rdRound = 4'd1;
    #1 chk("w6_192", rdKey[63:32], 32'hFE0C91F7);

    rdRound = 4'd14;
    kick(2'b10, K256);
    chk("small_err_256", err128, 1'b1);
    chk("small_no_busy", busy128, 1'b0);
    chk("small_valid_kept", keysValid128, 1'b1);
    chk("small_store_kept", rdKey128, R128_10);
    waitDone(0, lat);
    chk("lat256", 128'(lat), 128'd53);
    chk("rk256_r14", rdKey, R256_14);
    rdRound = 4'd2;
    #1 chk("w8_256", rdKey[127:96], 32'h9BA35411);

    // Reset mid AES-256 run, then a fresh AES-128 run
    kick(2'b10, K256);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", keysValid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdkey", rdKey, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    rdRound = 4'd10;
    kick(2'b00, K128);
    waitDone(0, lat);
    chk("lat128_after_rst", 128'(lat), 128'd41);
    chk("rk128_after_rst", rdKey, R128_10);
    chk("valid_after_rst_run", keysValid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
